nand3x2_tester: RTL and testbench
=================================

# nand3x2_tester

Self-checking exhaustive stimulus/response sequencer for a 2-lane, 3-input NAND array. It is the driving end of that array's interface: it generates all 64 input patterns on I0/I1/I2, waits a settle interval, samples the returned O, and compares it against the golden NAND result. It runs on-board (iCE40), with I0/I1/I2 wired out to the array and O wired back, and reports pass/fail, an error count and the first failing vector.

## Interface
Parameters:
- SETTLE, 2, extra cycles each vector is held before O is sampled; must be ≥1.
- ERR_W, 7, width of the error counter; the counter saturates at 2^ERR_W−1.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNCRESET  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- I0  out  2  lane inputs 0, equal to v[1:0].
- I1  out  2  lane inputs 1, equal to v[3:2].
- I2  out  2  lane inputs 2, equal to v[5:4].
- O  in  2  response from the array under test.
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 if err_count==0.
- err_count  out  ERR_W  number of failing vectors, saturating.
- first_fail  out  6  index v of the first failing vector; 0 if none.
- first_obs  out  2  O observed at first_fail.

## Operation
- Golden model: exp[k] = ~(I0[k] & I1[k] & I2[k]) for k = 0,1. A vector fails if O != exp; a vector is counted once regardless of how many lanes mismatch.
- State machine:
  - IDLE: on start, go to SETTLE with v=0; clear err_count, first_fail, first_obs and the fail_seen flag.
  - SETTLE: the settle counter runs 0..SETTLE−1, then the machine goes to CHECK.
  - CHECK: register O and compare it with exp.
    - On fail: err_count++ (saturating); if !fail_seen, capture first_fail=v and first_obs=O, then set fail_seen.
    - If v==63, go to DONE. Otherwise v++ and go to SETTLE.
  - DONE: done=1 and pass=(err_count==0). Both hold until start, which behaves exactly as start does in IDLE.
- start asserted in SETTLE or CHECK is ignored.
- I0/I1/I2 are driven directly from the registered v, with no combinational path from start or O.
- While idle or done, the outputs hold v at its last value (63 after a run, 0 after reset).
- Reset (asynchronous, at any time including mid-run):
  - state=IDLE, v=0, so I0=I1=I2=0.
  - busy=0, done=0, pass=0, err_count=0, first_fail=0, first_obs=0, fail_seen=0.

## Timing
- Each vector is driven for SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 cycle in CHECK. O is sampled at the rising edge that ends CHECK.
- Run length: start sampled at edge 0 → done rises after edge 64·(SETTLE+1). With SETTLE=2 that is 192 cycles.
- When CHECK sees v==63:
  - it is the last CHECK cycle;
  - done and the final err_count become visible in the same cycle;
  - busy falls in that same cycle.
- Wrap-around: v never wraps past 63; the v==63 CHECK ends the run.
- Saturation: once err_count equals 2^ERR_W−1, further fails leave it unchanged and pass stays 0.

## Structure
- Package nand3x2_pkg:
  - state enum {IDLE, SETTLE, CHECK, DONE};
  - constants VEC_W=6 and NVEC=64;
  - lane-split helper for v → I0/I1/I2.
- Sub-module nand3x2_golden: combinational, I0/I1/I2 → exp[1:0]. Instantiated once and reused by the bench as its reference model.
- The counters (v, settle, err) and the FSM stay in the top-level module.

## Test plan
- Good DUT model (O = golden NAND), SETTLE=2, pulse start → busy for 192 cycles, then done=1, pass=1, err_count=0, first_fail=0.
- O[1] stuck at 1 → fails exactly on the 8 vectors with v[1]=v[3]=v[5]=1; err_count=8, first_fail=6'h2A, first_obs=2'b11, pass=0.
- O fully inverted, ERR_W=4 → every vector fails; err_count saturates at 15, first_fail=0, first_obs=2'b00.
- ASYNCRESET pulsed mid-run (v≈20), without waiting for a clock edge → all outputs immediately take reset values, state=IDLE. A following start runs a clean 192-cycle pass.
- start re-pulsed during SETTLE/CHECK → ignored, run length unchanged. start in DONE after a failing run → counters clear and the rerun with a good DUT gives pass=1.
- SETTLE=1 with a DUT model delaying O by 2 cycles → failures are reported; with SETTLE=2 the same DUT passes. This checks that sampling occurs exactly at the end of CHECK.

Source files
------------

// File: rtl/nand3x2_pkg.sv
// Shared types and constants for the 2-lane, 3-input NAND array tester.
package nand3x2_pkg;

    localparam int VEC_W = 6;
    localparam int NVEC  = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] i2;
        logic [1:0] i1;
        logic [1:0] i0;
    } lanes_t;

    // Vector bit pairs map low-to-high onto I0, I1, I2.
    function automatic lanes_t split_lanes(input logic [VEC_W-1:0] v);
        lanes_t l;
        l.i0 = v[1:0];
        l.i1 = v[3:2];
        l.i2 = v[5:4];
        return l;
    endfunction

endpackage

// File: rtl/nand3x2_golden.sv
// Golden response of the array under test: per-lane 3-input NAND.
module nand3x2_golden (
    input  logic [1:0] i0,
    input  logic [1:0] i1,
    input  logic [1:0] i2,
    output logic [1:0] golden
);

    assign golden = ~(i0 & i1 & i2);

endmodule

// File: rtl/nand3x2_tester.sv
// Exhaustive stimulus/response sequencer for a 2-lane 3-input NAND array.
module nand3x2_tester
    import nand3x2_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 7
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             start,
    output logic [1:0]       I0,
    output logic [1:0]       I1,
    output logic [1:0]       I2,
    input  logic [1:0]       O,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [5:0]       first_fail,
    output logic [1:0]       first_obs
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] LAST_V = VEC_W'(NVEC - 1);

    state_t           state;
    logic [VEC_W-1:0] v;
    logic [CNT_W-1:0] settle_cnt;
    logic             fail_seen;
    logic [1:0]       exp_val;
    lanes_t           lanes;

    assign lanes = split_lanes(v);
    assign I0    = lanes.i0;
    assign I1    = lanes.i1;
    assign I2    = lanes.i2;

    nand3x2_golden u_golden (
        .i0     (I0),
        .i1     (I1),
        .i2     (I2),
        .golden (exp_val)
    );

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state      <= ST_IDLE;
            v          <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            first_obs  <= '0;
            fail_seen  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        v          <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        first_obs  <= '0;
                        fail_seen  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    // O is compared at the edge that ends CHECK, so the final
                    // count is already settled when DONE is entered.
                    if (O != exp_val) begin
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!fail_seen) begin
                            first_fail <= v;
                            first_obs  <= O;
                            fail_seen  <= 1'b1;
                        end
                    end
                    if (v == LAST_V) begin
                        state <= ST_DONE;
                    end else begin
                        v     <= v + VEC_W'(1);
                        state <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nand3x2_tester.sv
// Randomized self-checking bench: three tester instances driving modelled arrays.
module tb_nand3x2_tester;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       ASYNCRESET;
    logic       start_s [3];
    logic [1:0] i0_s [3];
    logic [1:0] i1_s [3];
    logic [1:0] i2_s [3];
    logic [1:0] o_s  [3];
    logic       busy_s [3];
    logic       done_s [3];
    logic       pass_s [3];
    logic [5:0] ff_s [3];
    logic [1:0] fo_s [3];
    logic [6:0] err_a;
    logic [3:0] err_b;
    logic [6:0] err_c;

    // Array behaviour: 0 good, 1 O[1] stuck-at-1, 2 inverted, 3 random flips, 4 two-cycle delay
    int         mode_s [3];
    logic [1:0] flip_t [64];
    logic [1:0] d1_s [3];
    logic [1:0] d2_s [3];

    int n_cmp = 0;
    int n_bad = 0;

    nand3x2_tester #(.SETTLE(2), .ERR_W(7)) dut_a (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .start(start_s[0]),
        .I0(i0_s[0]), .I1(i1_s[0]), .I2(i2_s[0]), .O(o_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_count(err_a), .first_fail(ff_s[0]), .first_obs(fo_s[0])
    );

    nand3x2_tester #(.SETTLE(2), .ERR_W(4)) dut_b (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .start(start_s[1]),
        .I0(i0_s[1]), .I1(i1_s[1]), .I2(i2_s[1]), .O(o_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_count(err_b), .first_fail(ff_s[1]), .first_obs(fo_s[1])
    );

    nand3x2_tester #(.SETTLE(1), .ERR_W(7)) dut_c (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .start(start_s[2]),
        .I0(i0_s[2]), .I1(i1_s[2]), .I2(i2_s[2]), .O(o_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
        .err_count(err_c), .first_fail(ff_s[2]), .first_obs(fo_s[2])
    );

    // A lane output is 0 only when all three of its inputs are 1.
    function automatic logic [1:0] nand_ref(input int a, input int b, input int c);
        logic [1:0] r;
        for (int k = 0; k < 2; k++) begin
            r[k] = ((((a >> k) & 1) + ((b >> k) & 1) + ((c >> k) & 1)) == 3) ? 1'b0 : 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        logic [1:0] g;
        for (int d = 0; d < 3; d++) begin
            g = nand_ref(int'(i0_s[d]), int'(i1_s[d]), int'(i2_s[d]));
            case (mode_s[d])
                1:       o_s[d] = g | 2'b10;
                2:       o_s[d] = ~g;
                3:       o_s[d] = g ^ flip_t[{i2_s[d], i1_s[d], i0_s[d]}];
                4:       o_s[d] = d2_s[d];
                default: o_s[d] = g;
            endcase
        end
    end

    always @(posedge CLK) begin
        for (int d = 0; d < 3; d++) begin
            d1_s[d] <= nand_ref(int'(i0_s[d]), int'(i1_s[d]), int'(i2_s[d]));
            d2_s[d] <= d1_s[d];
        end
    end

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic int err_of(input int d);
        case (d)
            0:       return int'(err_a);
            1:       return int'(err_b);
            default: return int'(err_c);
        endcase
    endfunction

    // Expected run result for array modes whose response depends only on the vector.
    task automatic model(input int mode, input int err_max,
                         output int e, output int ff, output int fo);
        logic [1:0] g, obs;
        bit seen;
        e = 0; ff = 0; fo = 0; seen = 0;
        for (int v = 0; v < 64; v++) begin
            g = nand_ref(v % 4, (v / 4) % 4, v / 16);
            case (mode)
                1:       obs = g | 2'b10;
                2:       obs = ~g;
                3:       obs = g ^ flip_t[v];
                default: obs = g;
            endcase
            if (obs != g) begin
                if (e < err_max) e++;
                if (!seen) begin
                    ff = v; fo = int'(obs); seen = 1;
                end
            end
        end
    endtask

    task automatic run(input int d, input int settle, input int rep_at, input string tag);
        int n, len, probe;
        len   = 64 * (settle + 1);
        probe = $urandom_range(1, len - 1);
        @(negedge CLK);
        start_s[d] = 1'b1;
        @(posedge CLK);
        #1;
        start_s[d] = 1'b0;
        check({tag, ".busy_at_start"}, int'(busy_s[d]), 1);
        n = 0;
        while (!done_s[d] && n < 4 * len) begin
            @(posedge CLK);
            #1;
            n++;
            start_s[d] = (rep_at != 0 && n == rep_at);
            if (n == probe)
                check({tag, ".vec"}, int'({i2_s[d], i1_s[d], i0_s[d]}), n / (settle + 1));
        end
        start_s[d] = 1'b0;
        check({tag, ".len"}, n, len);
        check({tag, ".done"}, int'(done_s[d]), 1);
        check({tag, ".busy_end"}, int'(busy_s[d]), 0);
        check({tag, ".last_vec"}, int'({i2_s[d], i1_s[d], i0_s[d]}), 63);
    endtask

    task automatic check_res(input int d, input string tag, input int e, input int ff, input int fo);
        check({tag, ".err_count"}, err_of(d), e);
        check({tag, ".first_fail"}, int'(ff_s[d]), ff);
        check({tag, ".first_obs"}, int'(fo_s[d]), fo);
        check({tag, ".pass"}, int'(pass_s[d]), (e == 0) ? 1 : 0);
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 3; d++) begin
            check({tag, ".busy"}, int'(busy_s[d]), 0);
            check({tag, ".done"}, int'(done_s[d]), 0);
            check({tag, ".pass"}, int'(pass_s[d]), 0);
            check({tag, ".err"}, err_of(d), 0);
            check({tag, ".ff"}, int'(ff_s[d]), 0);
            check({tag, ".fo"}, int'(fo_s[d]), 0);
            check({tag, ".vec"}, int'({i2_s[d], i1_s[d], i0_s[d]}), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, ff, fo, rep;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            mode_s[d]  = 0;
        end
        for (int v = 0; v < 64; v++) flip_t[v] = 2'b00;
        ASYNCRESET = 1'b1;
        #12;
        check_reset("reset");
        @(negedge CLK);
        ASYNCRESET = 1'b0;

        mode_s[0] = 0;
        run(0, 2, 0, "good");
        check_res(0, "good", 0, 0, 0);

        mode_s[0] = 1;
        run(0, 2, 0, "stuck1");
        check_res(0, "stuck1", 8, 42, 3);

        // Rerun from DONE after a failing run, with start re-pulsed mid-run.
        mode_s[0] = 0;
        rep = $urandom_range(5, 180);
        run(0, 2, rep, "rerun");
        check_res(0, "rerun", 0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 64; v++)
                flip_t[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mode_s[0] = 3;
            repeat ($urandom_range(0, 5)) @(posedge CLK);
            model(3, 127, e, ff, fo);
            run(0, 2, 0, $sformatf("rand%0d", r));
            check_res(0, $sformatf("rand%0d", r), e, ff, fo);
        end

        mode_s[1] = 2;
        run(1, 2, 0, "inv_sat");
        check_res(1, "inv_sat", 15, 0, 0);

        // Asynchronous reset around vector 20 of a failing run, away from any clock edge.
        mode_s[0] = 2;
        @(negedge CLK);
        start_s[0] = 1'b1;
        @(posedge CLK);
        #1;
        start_s[0] = 1'b0;
        repeat (61) @(posedge CLK);
        @(negedge CLK);
        check("midrst.busy_before", int'(busy_s[0]), 1);
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        mode_s[0] = 0;
        run(0, 2, 0, "after_rst");
        check_res(0, "after_rst", 0, 0, 0);

        mode_s[2] = 4;
        run(2, 1, 0, "delay_s1");
        check("delay_s1.pass", int'(pass_s[2]), 0);
        check("delay_s1.err_nonzero", (err_c != 7'd0) ? 1 : 0, 1);

        mode_s[0] = 4;
        run(0, 2, 0, "delay_s2");
        check_res(0, "delay_s2", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
